// File: rtl/softmax_pwl_eval_pkg.sv
// softmax_pwl_eval_pkg: coefficient table layout, Q-format default and 16-bit saturation helper
package softmax_pwl_eval_pkg;
    localparam int K_BASE   = 0;
    localparam int B_BASE   = 32;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;
    localparam int FRAC_DEF = 12;
    localparam int IDX_W    = ADDR_W - 1;

    function automatic logic [DATA_W-1:0] sat16(input logic signed [32:0] v);
        return v > 33'sd32767 ? 16'h7FFF : v < -33'sd32768 ? 16'h8000 : v[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/softmax_sync_fifo.sv
// softmax_sync_fifo: synchronous FIFO with occupancy count; an empty FIFO presents an all-zero head
module softmax_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    // a pop frees the slot in the same cycle, so push+pop is legal even when full
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign dout    = count == '0 ? '0 : mem[rptr];

    // storage written only on accepted pushes
    always_ff @(posedge aclk) begin
        if (do_push) mem[wptr] <= din;
    end

    // pointers wrap at DEPTH so non-power-of-two depths also work
    always_ff @(posedge aclk) begin
        if (areset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr == AW'(DEPTH - 1) ? '0 : wptr + 1'b1;
            if (do_pop) rptr <= rptr == AW'(DEPTH - 1) ? '0 : rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/softmax_pwl_eval.sv
// softmax_pwl_eval: per-lane piecewise-linear y = ((k*x) >>> FRAC) + b with ROM lookup and credit-guarded output FIFO
// Define SOFTMAX_PWL_SAT_EN to clamp the shifted product and the sum to 16-bit signed limits instead of wrapping.
module softmax_pwl_eval
    import softmax_pwl_eval_pkg::*;
#(
    parameter int LANES      = 10,
    parameter int FRAC       = FRAC_DEF,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*DATA_W-1:0]   s_x,
    output logic [LANES*ADDR_W-1:0]   addra,
    output logic [LANES*ADDR_W-1:0]   addrb,
    input  logic [LANES*DATA_W-1:0]   k,
    input  logic [LANES*DATA_W-1:0]   b,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*DATA_W-1:0]   m_y
);
    localparam int VW = LANES * DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                          accept;
    logic [VW-1:0]                 xd [ROM_LAT+1];
    logic [ROM_LAT:0]              vd;
    logic [LANES-1:0][31:0]        prod;
    logic [LANES-1:0][DATA_W-1:0]  p2, b2;
    logic                          v2;
    logic [VW-1:0]                 y3;
    logic [CW-1:0]                 inflight, fifo_count;
    logic [CW:0]                   occ;

    // credits cover everything between accept and pop, so the pipeline never needs to stall
    assign occ     = {1'b0, inflight} + {1'b0, fifo_count};
    assign s_ready = !areset && occ < (CW + 1)'(FIFO_DEPTH);
    assign accept  = s_valid && s_ready;
    assign m_valid = fifo_count != '0;

    // S1: slope/intercept addresses from the top five bits of x; held when nothing is accepted
    always_ff @(posedge aclk) begin
        if (areset) begin
            addra <= '0;
            addrb <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                addra[ADDR_W*i +: ADDR_W] <= ADDR_W'(K_BASE) | ADDR_W'(s_x[DATA_W*i + DATA_W - IDX_W +: IDX_W]);
                addrb[ADDR_W*i +: ADDR_W] <= ADDR_W'(B_BASE) | ADDR_W'(s_x[DATA_W*i + DATA_W - IDX_W +: IDX_W]);
            end
        end
    end

    // x captured at S1 and delayed to line up with the ROM read data
    always_ff @(posedge aclk) begin
        if (accept) xd[0] <= s_x;
        for (int j = 1; j <= ROM_LAT; j++) xd[j] <= xd[j-1];
    end

    // stage valids travel alongside the data through S1, the ROM latency and S2
    always_ff @(posedge aclk) begin
        if (areset) begin
            vd <= '0;
            v2 <= 1'b0;
        end else begin
            vd <= {vd[ROM_LAT-1:0], accept};
            v2 <= vd[ROM_LAT];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod[i] = 32'($signed(k[DATA_W*i +: DATA_W])) * 32'($signed(xd[ROM_LAT][DATA_W*i +: DATA_W]));
    end

    // S2: shifted product reduced to 16 bits, intercept carried alongside
    always_ff @(posedge aclk) begin
        for (int i = 0; i < LANES; i++) begin
`ifdef SOFTMAX_PWL_SAT_EN
            p2[i] <= sat16(33'($signed(prod[i]) >>> FRAC));
`else
            p2[i] <= DATA_W'($signed(prod[i]) >>> FRAC);
`endif
            b2[i] <= b[DATA_W*i +: DATA_W];
        end
    end

    // S3: add intercept; the result is pushed straight into the FIFO
    always_comb begin
        y3 = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SOFTMAX_PWL_SAT_EN
            y3[DATA_W*i +: DATA_W] = sat16(33'($signed(p2[i])) + 33'($signed(b2[i])));
`else
            y3[DATA_W*i +: DATA_W] = p2[i] + b2[i];
`endif
        end
    end

    // vectors in S1..S3: up on accept, down on FIFO push
    always_ff @(posedge aclk) begin
        if (areset) inflight <= '0;
        else inflight <= inflight + CW'(accept) - CW'(v2);
    end

    softmax_sync_fifo #(
        .W     (VW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (v2),
        .din    (y3),
        .pop    (m_ready),
        .dout   (m_y),
        .count  (fifo_count)
    );
endmodule

// File: tb/tb_softmax_pwl_eval.sv
// tb_softmax_pwl_eval: scoreboard bench with a registered 1-cycle coefficient ROM model
module tb_softmax_pwl_eval;
    localparam int L  = 10;
    localparam int VW = L * 16;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [VW-1:0]   s_x = '0;
    logic [L*6-1:0]  addra, addrb;
    logic [VW-1:0]   k, b;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [VW-1:0]   m_y;

    logic [15:0]     rom [64];
    logic [VW-1:0]   exp_q [$];
    int              checks = 0;
    int              errors = 0;
    int              rdy_mode = 0;
    int              occ = 0;
    int              max_occ = 0;

    always #5 aclk = ~aclk;

    softmax_pwl_eval dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_x     (s_x),
        .addra   (addra),
        .addrb   (addrb),
        .k       (k),
        .b       (b),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_y     (m_y)
    );

    always @(posedge aclk) begin
        for (int i = 0; i < L; i++) begin
            k[16*i +: 16] <= rom[addra[6*i +: 6]];
            b[16*i +: 16] <= rom[addrb[6*i +: 6]];
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
        end
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h need %h", name, act, req);
        end
    endtask

    always @(negedge aclk) begin
        if (areset) begin
            exp_q.delete();
            occ = 0;
        end else begin
            if (s_valid && s_ready) occ++;
            if (m_valid && m_ready) begin
                occ--;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %h need nothing", m_y);
                end else begin
                    chk("m_y", m_y, exp_q.pop_front());
                end
            end
            if (occ > max_occ) max_occ = occ;
        end
    end

    function automatic logic [VW-1:0] model(input logic [VW-1:0] x);
        logic [VW-1:0]      y;
        logic signed [15:0] xs, ks, bs;
        int                 idx, p, q, s;
        y = '0;
        for (int l = 0; l < L; l++) begin
            xs = x[16*l +: 16];
            idx = int'(x[16*l+11 +: 5]);
            ks = rom[idx];
            bs = rom[32+idx];
            p = int'(xs) * int'(ks);
            q = p >>> 12;
`ifdef SOFTMAX_PWL_SAT_EN
            q = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
            s = q + int'(bs);
            s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`else
            s = q + int'(bs);
`endif
            y[16*l +: 16] = 16'(s);
        end
        return y;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] x, input logic [VW-1:0] e);
        int n = 0;
        s_valid = 1'b1;
        s_x = x;
        @(negedge aclk);
        while (!s_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got s_ready=0 need 1");
        end else begin
            exp_q.push_back(e);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending need 0", exp_q.size());
        end
        tick();
    endtask

    task automatic rom_identity();
        for (int j = 0; j < 32; j++) begin
            rom[j] = 16'h1000;
            rom[32+j] = 16'h0000;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0]  xv, ev;
        logic [L*6-1:0] ea, eb;
        int             n;
        for (int j = 0; j < 64; j++) rom[j] = 16'h0000;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("s_ready_in_reset", s_ready, 0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        chk("s_ready_after_reset", s_ready, 1);
        chk("m_valid_after_reset", m_valid, 0);
        chk("m_y_after_reset", m_y, 0);
        chk("addra_after_reset", addra, 0);
        chk("addrb_after_reset", addrb, 0);
        rdy_mode = 1;
        tick();
        tick();

        rom[1] = 16'h1000;
        rom[33] = 16'h0100;
        send({L{16'h0800}}, {L{16'h0900}});
        @(negedge aclk);
        chk("basic_addra", addra, {L{6'd1}});
        chk("basic_addrb", addrb, {L{6'd33}});
        @(negedge aclk);
        @(negedge aclk);
        chk("basic_m_valid_early", m_valid, 0);
        @(negedge aclk);
        chk("basic_m_valid_lat4", m_valid, 1);
        wait_drain();

        for (int i = 0; i < L; i++) begin
            rom[i] = 16'h1000;
            rom[32+i] = 16'h0000;
            xv[16*i +: 16] = 16'(i << 11);
            ea[6*i +: 6] = 6'(i);
            eb[6*i +: 6] = 6'(32 + i);
        end
        send(xv, xv);
        @(negedge aclk);
        chk("lane_addra", addra, ea);
        chk("lane_addrb", addrb, eb);
        wait_drain();

        rom[15] = 16'h7FFF;
        rom[47] = 16'h0000;
        rom[16] = 16'h7FFF;
        rom[48] = 16'h0000;
        send({L{16'h7FFF}},
`ifdef SOFTMAX_PWL_SAT_EN
            {L{16'h7FFF}});
`else
            {L{16'hFFF0}});
`endif
        for (int i = 0; i < L; i++) begin
            xv[16*i +: 16] = i % 2 == 0 ? 16'h7FFF : 16'h8000;
`ifdef SOFTMAX_PWL_SAT_EN
            ev[16*i +: 16] = i % 2 == 0 ? 16'h7FFF : 16'h8000;
`else
            ev[16*i +: 16] = i % 2 == 0 ? 16'hFFF0 : 16'h0008;
`endif
        end
        send(xv, ev);
        wait_drain();

        rom_identity();
        rdy_mode = 0;
        tick();
        tick();
        n = 0;
        s_valid = 1'b1;
        for (int i = 0; i < L; i++) s_x[16*i +: 16] = 16'($urandom);
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (s_ready) begin
                exp_q.push_back(s_x);
                n++;
            end
            tick();
            for (int i = 0; i < L; i++) s_x[16*i +: 16] = 16'($urandom);
        end
        s_valid = 1'b0;
        @(negedge aclk);
        chk("bp_accepted", VW'(n), 4);
        chk("bp_s_ready_low", s_ready, 0);
        chk("bp_head", m_y, exp_q[0]);
        tick();
        @(negedge aclk);
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_y, exp_q[0]);
        rdy_mode = 1;
        wait_drain();

        for (int j = 0; j < 64; j++) rom[j] = 16'($urandom);
        rdy_mode = 2;
        for (int v = 0; v < 100; v++) begin
            for (int i = 0; i < L; i++) xv[16*i +: 16] = 16'($urandom);
            send(xv, model(xv));
        end
        rdy_mode = 1;
        wait_drain();
        chk("occ_le_depth", max_occ <= 4, 1);

        rom_identity();
        rdy_mode = 0;
        tick();
        tick();
        send({L{16'h1234}}, {L{16'h1234}});
        repeat (5) @(negedge aclk);
        chk("rst_queued", m_valid, 1);
        tick();
        send({L{16'h2345}}, {L{16'h2345}});
        send({L{16'h3456}}, {L{16'h3456}});
        send({L{16'h4567}}, {L{16'h4567}});
        areset = 1'b1;
        @(negedge aclk);
        chk("rst_s_ready_during", s_ready, 0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_y", m_y, 0);
        chk("rst_addra", addra, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_s_ready_after", s_ready, 1);
        rdy_mode = 1;
        repeat (10) @(negedge aclk);
        chk("rst_no_stale", m_valid, 0);
        tick();
        send({L{16'h0ABC}}, {L{16'h0ABC}});
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
